// File: rtl/motion_pkg.sv
// Shared types, defaults and helpers for the motion-difference highlight pipeline.
package motion_pkg;

    localparam int unsigned DEF_CHANNELS      = 3;
    localparam int unsigned DEF_CHANNEL_WIDTH = 8;
    localparam int unsigned MAX_CHANNEL_WIDTH = 16;

    localparam logic [DEF_CHANNELS*DEF_CHANNEL_WIDTH-1:0] DEF_HIGHLIGHT_COLOR = 24'hFF0000;

    typedef enum logic [1:0] {
        MODE_OVERLAY = 2'd0,
        MODE_MASK    = 2'd1,
        MODE_DIFF    = 2'd2
    } mode_e;

    // Magnitude of a signed gray difference; callers sign-extend into the widest supported width.
    function automatic logic [MAX_CHANNEL_WIDTH-1:0] abs_diff(input logic signed [MAX_CHANNEL_WIDTH:0] d);
        logic signed [MAX_CHANNEL_WIDTH:0] mag;
        mag = d[MAX_CHANNEL_WIDTH] ? -d : d;
        return mag[MAX_CHANNEL_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/motion_frame_stats.sv
// Per-frame bookkeeping: pixel position, frame-start parameter latch and motion summary.
module motion_frame_stats
    import motion_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH     = DEF_CHANNEL_WIDTH,
    parameter int unsigned FRAME_PIXELS      = 768*576,
    parameter int unsigned MIN_MOTION_PIXELS = 1,
    parameter int unsigned COUNT_WIDTH       = $clog2(FRAME_PIXELS+1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pop,
    input  logic [CHANNEL_WIDTH-1:0] threshold,
    input  logic [1:0]               mode,
    input  logic                     motion_load,
    input  logic                     last_write,
    output logic [CHANNEL_WIDTH-1:0] thr_latched,
    output logic [1:0]               mode_latched,
    output logic                     last_pixel_c,
    output logic                     frame_done,
    output logic [COUNT_WIDTH-1:0]   motion_count,
    output logic                     motion_flag
);

    logic [COUNT_WIDTH-1:0] pixel_count;
    logic [COUNT_WIDTH-1:0] motion_acc;

    assign last_pixel_c = (pixel_count == COUNT_WIDTH'(FRAME_PIXELS - 1));

    // Pixel position within the frame; parameters are captured by the pop of pixel 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_count  <= '0;
            thr_latched  <= '0;
            mode_latched <= '0;
        end else if (pop) begin
            pixel_count <= last_pixel_c ? '0 : pixel_count + COUNT_WIDTH'(1);
            if (pixel_count == '0) begin
                thr_latched  <= threshold;
                mode_latched <= mode;
            end
        end
    end

    // A motion pixel entering S2 in the same cycle as the last write belongs to the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            motion_acc   <= '0;
            motion_count <= '0;
            motion_flag  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= last_write;
            if (last_write) begin
                motion_count <= motion_acc;
                motion_flag  <= (motion_acc >= COUNT_WIDTH'(MIN_MOTION_PIXELS));
                motion_acc   <= motion_load ? COUNT_WIDTH'(1) : '0;
            end else if (motion_load) begin
                motion_acc <= motion_acc + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/motion_diff_highlight.sv
// Fused background-subtract and highlight stage: three show-ahead FIFOs in, one FIFO out,
// two-stage pipeline with per-frame motion summary.
module motion_diff_highlight
    import motion_pkg::*;
#(
    parameter int unsigned CHANNELS          = DEF_CHANNELS,
    parameter int unsigned CHANNEL_WIDTH     = DEF_CHANNEL_WIDTH,
    parameter int unsigned PIXEL_WIDTH       = CHANNELS*CHANNEL_WIDTH,
    parameter int unsigned FRAME_PIXELS      = 768*576,
    parameter logic [PIXEL_WIDTH-1:0] HIGHLIGHT_COLOR = DEF_HIGHLIGHT_COLOR,
    parameter int unsigned MIN_MOTION_PIXELS = 1,
    parameter int unsigned COUNT_WIDTH       = $clog2(FRAME_PIXELS+1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNEL_WIDTH-1:0] threshold,
    input  logic [1:0]               mode,
    output logic                     bg_rd_en,
    input  logic                     bg_empty,
    input  logic [CHANNEL_WIDTH-1:0] bg_dout,
    output logic                     fr_rd_en,
    input  logic                     fr_empty,
    input  logic [CHANNEL_WIDTH-1:0] fr_dout,
    output logic                     img_rd_en,
    input  logic                     img_empty,
    input  logic [PIXEL_WIDTH-1:0]   img_dout,
    output logic                     out_wr_en,
    input  logic                     out_full,
    output logic [PIXEL_WIDTH-1:0]   out_din,
    output logic                     frame_done,
    output logic [COUNT_WIDTH-1:0]   motion_count,
    output logic                     motion_flag
);

    logic                     s1_valid;
    logic                     s1_last;
    logic [CHANNEL_WIDTH-1:0] s1_diff;
    logic [PIXEL_WIDTH-1:0]   s1_img;
    logic                     s2_valid;
    logic                     s2_last;

    logic                         s2_load_c;
    logic                         s1_load_c;
    logic                         pop_c;
    logic                         motion_c;
    logic [PIXEL_WIDTH-1:0]       pix_c;
    logic signed [CHANNEL_WIDTH:0] sub_c;

    logic [CHANNEL_WIDTH-1:0] thr_latched;
    logic [1:0]               mode_latched;
    logic                     last_pixel_c;

    // Backpressure ripples from the output FIFO towards the inputs within one cycle.
    assign s2_load_c = !s2_valid || !out_full;
    assign s1_load_c = !s1_valid || s2_load_c;
    assign pop_c     = s1_load_c && !bg_empty && !fr_empty && !img_empty;

    assign bg_rd_en  = pop_c;
    assign fr_rd_en  = pop_c;
    assign img_rd_en = pop_c;

    assign out_wr_en = s2_valid && !out_full;

    assign sub_c = $signed({1'b0, fr_dout}) - $signed({1'b0, bg_dout});

    // Output pixel selection; the reserved mode falls back to overlay.
    always_comb begin
        motion_c = (s1_diff > thr_latched);
        pix_c    = s1_img;
        case (mode_e'(mode_latched))
            MODE_MASK: pix_c = motion_c ? '1 : '0;
            MODE_DIFF: pix_c = {CHANNELS{s1_diff}};
            default:   pix_c = motion_c ? HIGHLIGHT_COLOR : s1_img;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_diff  <= '0;
            s1_img   <= '0;
        end else if (s1_load_c) begin
            s1_valid <= pop_c;
            s1_last  <= last_pixel_c;
            s1_diff  <= CHANNEL_WIDTH'(abs_diff((MAX_CHANNEL_WIDTH+1)'(sub_c)));
            s1_img   <= img_dout;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            out_din  <= '0;
        end else if (s2_load_c) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            out_din  <= pix_c;
        end
    end

    motion_frame_stats #(
        .CHANNEL_WIDTH     (CHANNEL_WIDTH),
        .FRAME_PIXELS      (FRAME_PIXELS),
        .MIN_MOTION_PIXELS (MIN_MOTION_PIXELS),
        .COUNT_WIDTH       (COUNT_WIDTH)
    ) u_stats (
        .clock        (clock),
        .reset        (reset),
        .pop          (pop_c),
        .threshold    (threshold),
        .mode         (mode),
        .motion_load  (s2_load_c && s1_valid && motion_c),
        .last_write   (out_wr_en && s2_last),
        .thr_latched  (thr_latched),
        .mode_latched (mode_latched),
        .last_pixel_c (last_pixel_c),
        .frame_done   (frame_done),
        .motion_count (motion_count),
        .motion_flag  (motion_flag)
    );

endmodule

// File: tb/tb_motion_diff_highlight.sv
// Scoreboard bench for motion_diff_highlight with 4-pixel frames and bench-side FIFOs.
module tb_motion_diff_highlight;

    localparam int unsigned FP  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned PW  = 24;
    localparam int unsigned CNW = $clog2(FP+1);
    localparam logic [PW-1:0] HL = 24'hFF0000;

    logic           clock = 1'b0;
    logic           reset;
    logic [CW-1:0]  threshold;
    logic [1:0]     mode;
    logic           bg_rd_en, fr_rd_en, img_rd_en;
    logic           bg_empty, fr_empty, img_empty;
    logic [CW-1:0]  bg_dout, fr_dout;
    logic [PW-1:0]  img_dout;
    logic           out_wr_en;
    logic           out_full;
    logic [PW-1:0]  out_din;
    logic           frame_done;
    logic [CNW-1:0] motion_count;
    logic           motion_flag;

    logic [CW-1:0] bg_mem  [0:63];
    logic [CW-1:0] fr_mem  [0:63];
    logic [PW-1:0] img_mem [0:63];
    int rd_idx = 0;
    int wr_idx = 0;

    logic [PW-1:0] exp_q[$];
    int            sum_cnt_q[$];
    bit            sum_flag_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    bit last_wr = 1'b0;

    always #5 clock = ~clock;

    motion_diff_highlight #(.FRAME_PIXELS(FP)) dut (
        .clock        (clock),
        .reset        (reset),
        .threshold    (threshold),
        .mode         (mode),
        .bg_rd_en     (bg_rd_en),
        .bg_empty     (bg_empty),
        .bg_dout      (bg_dout),
        .fr_rd_en     (fr_rd_en),
        .fr_empty     (fr_empty),
        .fr_dout      (fr_dout),
        .img_rd_en    (img_rd_en),
        .img_empty    (img_empty),
        .img_dout     (img_dout),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .out_din      (out_din),
        .frame_done   (frame_done),
        .motion_count (motion_count),
        .motion_flag  (motion_flag)
    );

    // Show-ahead FIFO models sharing one read pointer; alignment of the pops is checked separately.
    assign bg_empty  = (rd_idx >= wr_idx);
    assign fr_empty  = (rd_idx >= wr_idx);
    assign img_empty = (rd_idx >= wr_idx);
    assign bg_dout   = bg_mem[rd_idx[5:0]];
    assign fr_dout   = fr_mem[rd_idx[5:0]];
    assign img_dout  = img_mem[rd_idx[5:0]];

    always @(posedge clock) begin
        if (bg_rd_en) rd_idx <= rd_idx + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected pixels/summaries whenever the DUT writes or signals frame end.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            wr_cnt  = 0;
            last_wr = 1'b0;
        end else begin
            check("frame_done_timing", 32'(frame_done), 32'(last_wr));
            if (frame_done) begin
                check("summary_avail", 32'(sum_cnt_q.size() > 0), 32'd1);
                if (sum_cnt_q.size() > 0) begin
                    check("motion_count", 32'(motion_count), 32'(sum_cnt_q.pop_front()));
                    check("motion_flag", 32'(motion_flag), 32'(sum_flag_q.pop_front()));
                end
            end
            last_wr = 1'b0;
            if (out_full) check("wr_during_full", 32'(out_wr_en), 32'd0);
            if (out_wr_en) begin
                check("out_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("out_din", 32'(out_din), 32'(exp_q.pop_front()));
                wr_cnt++;
                if (wr_cnt == FP) begin
                    wr_cnt  = 0;
                    last_wr = 1'b1;
                end
            end
            check("rd_en_align", 32'({fr_rd_en, img_rd_en}), 32'({bg_rd_en, bg_rd_en}));
            if (bg_empty || fr_empty || img_empty)
                check("rd_en_when_empty", 32'(bg_rd_en), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [CW-1:0] b, input logic [CW-1:0] f,
                        input logic [PW-1:0] im, input logic [PW-1:0] ex);
        bg_mem[wr_idx[5:0]]  = b;
        fr_mem[wr_idx[5:0]]  = f;
        img_mem[wr_idx[5:0]] = im;
        wr_idx++;
        exp_q.push_back(ex);
    endtask

    task automatic push_sum(input int c, input bit fl);
        sum_cnt_q.push_back(c);
        sum_flag_q.push_back(fl);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && sum_cnt_q.size() == 0) break;
            tick();
        end
        check("drain", 32'(exp_q.size() + sum_cnt_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 50; i++) begin
            if (rd_idx >= target) break;
            tick();
        end
        check("pop_wait", 32'(rd_idx >= target), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 64; i++) begin
            bg_mem[i] = '0; fr_mem[i] = '0; img_mem[i] = '0;
        end
        reset = 1'b1; threshold = '0; mode = 2'd0; out_full = 1'b0;
        repeat (3) tick();
        check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_out_din", 32'(out_din), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_motion_count", 32'(motion_count), 32'd0);
        check("rst_motion_flag", 32'(motion_flag), 32'd0);
        check("rst_rd_en", 32'(bg_rd_en), 32'd0);
        reset = 1'b0;

        // Idle with all FIFOs empty.
        repeat (10) begin
            tick();
            check("idle_rd_en", 32'({bg_rd_en, fr_rd_en, img_rd_en}), 32'd0);
            check("idle_wr_en", 32'(out_wr_en), 32'd0);
        end

        // Overlay, threshold 10; 10 is not motion (strict compare).
        threshold = 8'd10; mode = 2'd0;
        push(8'd0, 8'd5,   24'h123456, 24'h123456);
        push(8'd0, 8'd11,  24'h123456, HL);
        push(8'd0, 8'd10,  24'h123456, 24'h123456);
        push(8'd0, 8'd200, 24'h123456, HL);
        push_sum(2, 1'b1);
        drain();

        // Mask, threshold 0, identical gray.
        threshold = 8'd0; mode = 2'd1;
        for (int i = 0; i < 4; i++) push(8'd50, 8'd50, 24'h654321, 24'h000000);
        push_sum(0, 1'b0);
        drain();

        // Raw difference including the fr < bg underflow case.
        threshold = 8'd10; mode = 2'd2;
        push(8'd200, 8'd20,  24'h0, 24'hB4B4B4);
        push(8'd200, 8'd200, 24'h0, 24'h000000);
        push(8'd255, 8'd0,   24'h0, 24'hFFFFFF);
        push(8'd0,   8'd255, 24'h0, 24'hFFFFFF);
        push_sum(3, 1'b1);
        drain();

        // Output stall mid-frame.
        threshold = 8'd10; mode = 2'd0;
        base = rd_idx;
        push(8'd0, 8'd20, 24'h111111, HL);
        push(8'd0, 8'd0,  24'h222222, 24'h222222);
        push(8'd0, 8'd30, 24'h333333, HL);
        push(8'd0, 8'd5,  24'h444444, 24'h444444);
        push_sum(2, 1'b1);
        wait_pops(base + 2);
        out_full = 1'b1;
        base = rd_idx;
        repeat (5) tick();
        check("stall_pops_le2", 32'((rd_idx - base) > 2), 32'd0);
        out_full = 1'b0;
        drain();

        // Threshold change mid-frame applies only from the next frame; frames back to back.
        threshold = 8'd10; mode = 2'd0;
        base = rd_idx;
        for (int i = 0; i < 4; i++) push(8'd0, 8'd50, 24'h5A5A5A, HL);
        push_sum(4, 1'b1);
        push(8'd0, 8'd150, 24'hAAAAAA, HL);
        push(8'd0, 8'd50,  24'hBBBBBB, 24'hBBBBBB);
        push(8'd0, 8'd100, 24'hCCCCCC, 24'hCCCCCC);
        push(8'd0, 8'd101, 24'hDDDDDD, HL);
        push_sum(2, 1'b1);
        wait_pops(base + 2);
        threshold = 8'd100;
        drain();

        // Reset after pixel 2 of a frame is popped.
        base = rd_idx;
        for (int i = 0; i < 3; i++) push(8'd0, 8'd0, 24'h777777, 24'h777777);
        wait_pops(base + 3);
        reset = 1'b1;
        #1;
        check("midrst_out_wr_en", 32'(out_wr_en), 32'd0);
        check("midrst_out_din", 32'(out_din), 32'd0);
        check("midrst_motion_count", 32'(motion_count), 32'd0);
        check("midrst_motion_flag", 32'(motion_flag), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        push(8'd0, 8'd150, 24'h010101, HL);
        push(8'd0, 8'd10,  24'h020202, 24'h020202);
        push(8'd0, 8'd255, 24'h030303, HL);
        push(8'd0, 8'd101, 24'h040404, HL);
        push_sum(3, 1'b1);
        drain();

        check("leftover_pixels", 32'(exp_q.size()), 32'd0);
        check("leftover_frames", 32'(sum_cnt_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
